// File: rtl/ascon_bdi_pad_if.sv
// ascon_bdi_pad_if: host word stream in, padded bdi stream out.
interface ascon_bdi_pad_if #(parameter int CCW = 32);
    logic [CCW-1:0] s_data;
    logic [3:0]     s_keep;
    logic [3:0]     s_type;
    logic           s_last;
    logic           s_eoi;
    logic           s_valid;
    logic           s_ready;
    logic [CCW-1:0] bdi;
    logic [3:0]     bdi_type;
    logic           bdi_eot;
    logic           bdi_eoi;
    logic           bdi_valid;
    logic           bdi_ready;
    modport master (
        output s_data, s_keep, s_type, s_last, s_eoi, s_valid, bdi_ready,
        input  s_ready, bdi, bdi_type, bdi_eot, bdi_eoi, bdi_valid
    );
    modport slave (
        input  s_data, s_keep, s_type, s_last, s_eoi, s_valid, bdi_ready,
        output s_ready, bdi, bdi_type, bdi_eot, bdi_eoi, bdi_valid
    );
endinterface

// File: rtl/ascon_bdi_pad.sv
// ascon_bdi_pad: applies Ascon 10* padding to AD/PTCT words ahead of the core's bdi port.
// Define ASCON_PAD_CHECK_EN to compile in the sticky host-protocol checker driving err_o.
module ascon_bdi_pad #(
    parameter int CCW = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    ascon_bdi_pad_if.slave bus,
    output logic           err_o
);
    localparam logic [3:0] D_NULL  = 4'd0;
    localparam logic [3:0] D_NONCE = 4'd1;
    localparam logic [3:0] D_AD    = 4'd2;
    localparam logic [3:0] D_PTCT  = 4'd3;
    localparam logic [3:0] D_TAG   = 4'd4;
    typedef enum logic {PASS, PAD} state_t;
    state_t         state_q, state_d;
    logic [CCW-1:0] bdi_q, bdi_d, mask, pad_bits, fmt;
    logic [3:0]     type_q, type_d, lat_type_q;
    logic           eot_q, eot_d, eoi_q, eoi_d, valid_q, valid_d, lat_eoi_q;
    logic           free, acc, padded, full_last, pad_load, eot_in;
    assign free      = !valid_q | bus.bdi_ready;
    assign bus.s_ready = (state_q == PASS) & free;
    assign acc       = bus.s_valid & bus.s_ready;
    assign padded    = (bus.s_type == D_AD) | (bus.s_type == D_PTCT);
    assign full_last = padded & bus.s_last & (bus.s_keep == 4'b1111);
    assign pad_load  = (state_q == PAD) & free;
    assign mask      = {{8{bus.s_keep[3]}}, {8{bus.s_keep[2]}}, {8{bus.s_keep[1]}}, {8{bus.s_keep[0]}}};
    // 0x80 lands in the first byte not covered by s_keep; a full word gets no pad here
    assign pad_bits  = (bus.s_keep == 4'b1110) ? 32'h0000_0080 :
                       (bus.s_keep == 4'b1100) ? 32'h0000_8000 :
                       (bus.s_keep == 4'b1000) ? 32'h0080_0000 :
                       (bus.s_keep == 4'b0000) ? 32'h8000_0000 : 32'h0;
    assign fmt       = (padded & bus.s_last) ? ((bus.s_data & mask) | pad_bits) : bus.s_data;
    assign eot_in    = bus.s_last & !full_last;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= PASS;
        else        state_q <= state_d;
    end
    always_comb state_d = (state_q == PASS) ? ((acc & full_last) ? PAD : PASS) : (free ? PASS : PAD);
    always_comb begin
        bdi_d   = pad_load ? 32'h8000_0000 : acc ? fmt : bdi_q;
        type_d  = pad_load ? lat_type_q : acc ? bus.s_type : type_q;
        eot_d   = pad_load ? 1'b1 : acc ? eot_in : eot_q;
        eoi_d   = pad_load ? lat_eoi_q : acc ? (eot_in & bus.s_eoi) : eoi_q;
        valid_d = acc | pad_load | (valid_q & !bus.bdi_ready);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bdi_q      <= '0;
            type_q     <= D_NULL;
            eot_q      <= 1'b0;
            eoi_q      <= 1'b0;
            valid_q    <= 1'b0;
            lat_type_q <= D_NULL;
            lat_eoi_q  <= 1'b0;
        end else begin
            bdi_q   <= bdi_d;
            type_q  <= type_d;
            eot_q   <= eot_d;
            eoi_q   <= eoi_d;
            valid_q <= valid_d;
            if (acc & full_last) begin
                lat_type_q <= bus.s_type;
                lat_eoi_q  <= bus.s_eoi;
            end
        end
    end
    assign bus.bdi       = bdi_q;
    assign bus.bdi_type  = type_q;
    assign bus.bdi_eot   = eot_q;
    assign bus.bdi_eoi   = eoi_q;
    assign bus.bdi_valid = valid_q;
`ifdef ASCON_PAD_CHECK_EN
    logic [1:0] cnt_q;
    logic       err_q, nt, bad;
    assign nt  = (bus.s_type == D_NONCE) | (bus.s_type == D_TAG);
    assign bad = !(bus.s_keep inside {4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000})
               | ((bus.s_keep != 4'b1111) & !bus.s_last)
               | (nt & (bus.s_keep != 4'b1111))
               | (nt & bus.s_last & (cnt_q != 2'd3));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            err_q <= 1'b0;
        end else begin
            if (acc & nt) cnt_q <= bus.s_last ? 2'd0 : cnt_q + 2'd1;
            err_q <= err_q | (acc & bad);
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_ascon_bdi_pad.sv
// tb_ascon_bdi_pad: directed vectors with a scoreboard queue checked by a bdi-handshake monitor.
module tb_ascon_bdi_pad;
    localparam logic [3:0] D_NULL  = 4'd0;
    localparam logic [3:0] D_NONCE = 4'd1;
    localparam logic [3:0] D_AD    = 4'd2;
    localparam logic [3:0] D_PTCT  = 4'd3;
    localparam logic [3:0] D_TAG   = 4'd4;
    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  t;
        logic        eot;
        logic        eoi;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err;
    exp_t q[$];
    int checks = 0;
    int errors = 0;
    ascon_bdi_pad_if bus ();
    ascon_bdi_pad dut (.clk(clk), .rst_n(rst_n), .bus(bus), .err_o(err));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask
    task automatic expect_w(input logic [31:0] d, input logic [3:0] t, input logic eot, input logic eoi);
        q.push_back({d, t, eot, eoi});
    endtask
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic [3:0] t,
                        input logic l, input logic e);
        int n = 0;
        logic ok;
        bus.s_data = d; bus.s_keep = k; bus.s_type = t; bus.s_last = l; bus.s_eoi = e;
        bus.s_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %h not accepted, required within 50 cycles", d);
        end
        bus.s_valid = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("queue_drained", 64'(q.size()), 64'd0);
    endtask
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        if (rst_n && bus.bdi_valid && bus.bdi_ready) begin
            got = {bus.bdi, bus.bdi_type, bus.bdi_eot, bus.bdi_eoi};
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h expected none", got);
            end else begin
                e = q.pop_front();
                chk("bdi_word", 64'(got), 64'(e));
            end
        end
    end
    initial begin
        bus.s_data = '0; bus.s_keep = '0; bus.s_type = D_NULL;
        bus.s_last = 1'b0; bus.s_eoi = 1'b0; bus.s_valid = 1'b0; bus.bdi_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {bus.bdi, bus.bdi_type, bus.bdi_eot, bus.bdi_eoi, bus.bdi_valid, err}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_s_ready", 64'(bus.s_ready), 64'd1);
        @(posedge clk);
        #1;
        expect_w(32'h00010203, D_NONCE, 1'b0, 1'b0);
        expect_w(32'h04050607, D_NONCE, 1'b0, 1'b0);
        expect_w(32'h08090A0B, D_NONCE, 1'b0, 1'b0);
        expect_w(32'h0C0D0E0F, D_NONCE, 1'b1, 1'b0);
        send(32'h00010203, 4'b1111, D_NONCE, 1'b0, 1'b0);
        chk("nonce_latency", {bus.bdi_valid, bus.bdi}, {1'b1, 32'h00010203});
        send(32'h04050607, 4'b1111, D_NONCE, 1'b0, 1'b0);
        send(32'h08090A0B, 4'b1111, D_NONCE, 1'b0, 1'b0);
        send(32'h0C0D0E0F, 4'b1111, D_NONCE, 1'b1, 1'b0);
        expect_w(32'hAABBCC80, D_AD, 1'b1, 1'b0);
        send(32'hAABBCC11, 4'b1110, D_AD, 1'b1, 1'b0);
        expect_w(32'h12348000, D_PTCT, 1'b1, 1'b0);
        send(32'h12345678, 4'b1100, D_PTCT, 1'b1, 1'b0);
        expect_w(32'hCA800000, D_AD, 1'b1, 1'b0);
        send(32'hCAFEBABE, 4'b1000, D_AD, 1'b1, 1'b0);
        expect_w(32'h11111111, D_PTCT, 1'b0, 1'b0);
        expect_w(32'h22222222, D_PTCT, 1'b0, 1'b0);
        expect_w(32'h80000000, D_PTCT, 1'b1, 1'b1);
        send(32'h11111111, 4'b1111, D_PTCT, 1'b0, 1'b0);
        send(32'h22222222, 4'b1111, D_PTCT, 1'b1, 1'b1);
        @(negedge clk);
        chk("pad_s_ready_low", 64'(bus.s_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("pad_s_ready_back", 64'(bus.s_ready), 64'd1);
        @(posedge clk);
        #1;
        expect_w(32'h80000000, D_AD, 1'b1, 1'b1);
        send(32'hDEADBEEF, 4'b0000, D_AD, 1'b1, 1'b1);
        expect_w(32'hA1A2A3A4, D_TAG, 1'b0, 1'b0);
        expect_w(32'hB1B2B3B4, D_TAG, 1'b0, 1'b0);
        expect_w(32'hC1C2C3C4, D_TAG, 1'b0, 1'b0);
        expect_w(32'hD1D2D3D4, D_TAG, 1'b1, 1'b1);
        send(32'hA1A2A3A4, 4'b1111, D_TAG, 1'b0, 1'b0);
        send(32'hB1B2B3B4, 4'b1111, D_TAG, 1'b0, 1'b0);
        send(32'hC1C2C3C4, 4'b1111, D_TAG, 1'b0, 1'b0);
        send(32'hD1D2D3D4, 4'b1111, D_TAG, 1'b1, 1'b1);
        expect_w(32'h01020304, D_AD, 1'b0, 1'b0);
        send(32'h01020304, 4'b1111, D_AD, 1'b0, 1'b0);
        bus.bdi_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("backpressure_hold", {bus.bdi, bus.bdi_valid, bus.s_ready}, {32'h01020304, 1'b1, 1'b0});
            @(posedge clk);
            #1;
        end
        bus.bdi_ready = 1'b1;
        expect_w(32'h05060780, D_AD, 1'b1, 1'b0);
        send(32'h05060708, 4'b1110, D_AD, 1'b1, 1'b0);
        drain();
        chk("err_clean", 64'(err), 64'd0);
        expect_w(32'h55AA55AA, D_AD, 1'b0, 1'b0);
        send(32'h55AA55AA, 4'b1010, D_AD, 1'b0, 1'b0);
        @(negedge clk);
`ifdef ASCON_PAD_CHECK_EN
        chk("err_set", 64'(err), 64'd1);
`else
        chk("err_tied_low", 64'(err), 64'd0);
`endif
        repeat (3) @(posedge clk);
        #1;
`ifdef ASCON_PAD_CHECK_EN
        chk("err_sticky", 64'(err), 64'd1);
`else
        chk("err_still_low", 64'(err), 64'd0);
`endif
        drain();
        bus.bdi_ready = 1'b0;
        send(32'h33333333, 4'b1111, D_PTCT, 1'b1, 1'b1);
        @(negedge clk);
        chk("pad_entered", {bus.bdi_valid, bus.s_ready, bus.bdi}, {1'b1, 1'b0, 32'h33333333});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {bus.bdi, bus.bdi_type, bus.bdi_eot, bus.bdi_eoi, bus.bdi_valid, err}, 64'd0);
        chk("async_reset_pass", 64'(bus.s_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.bdi_ready = 1'b1;
        expect_w(32'h80000000, D_AD, 1'b1, 1'b1);
        send(32'h00000000, 4'b0000, D_AD, 1'b1, 1'b1);
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
